coproc_argext_stream: RTL and testbench
=======================================

// Module: coproc_argext_stream
// PURPOSE
// - Parametrised successor of the custom0 argmax stream coprocessor: running arg-max or arg-min over an operand stream.
// - Sits between the core's custom0 request/response genfifos in sigma_tile; one request in, one response out.
// - Adds over the previous generation: commands (clear/accumulate/read), 1- or 2-element pushes,
//   signed compare, an empty flag, response backpressure and index overflow protection.
// PARAMETERS
// - DATA_W   32  operand width, 1..32
// - IDX_W    16  running index width
// - SIGNED   0   1: two's-complement compare; 0: unsigned compare
// - FIND_MIN 0   1: arg-min; 0: arg-max
// PORTS
// - clk_i        in   1       clock
// - rst_i        in   1       reset, asynchronous, active-high
// - req_i        in   1       request valid
// - req_ack_o    out  1       request accepted (combinational)
// - req_cmd_bi   in   3       command (argext_cmd_t)
// - req_src0_bi  in   DATA_W  element at index cnt
// - req_src1_bi  in   DATA_W  element at index cnt+1 (ACC2 only)
// - resp_req_o   out  1       response valid
// - resp_data_bo out  32      response payload
// - resp_ack_i   in   1       response consumed
// BEHAVIOUR
// - Reset, asynchronous: resp_req_o=0, resp_data_bo=0, cnt=0, best_idx=0, best_val=0, valid=0, FSM=IDLE.
// - Handshake: req_ack_o = req_i & (state==IDLE | resp_ack_i). Only one response is outstanding at a time.
//   - If a request is accepted in cycle N, resp_req_o=1 from cycle N+1.
//   - resp_data_bo is held stable until resp_ack_i.
//   - Accept-while-ack in the same cycle is allowed: one request per cycle at full throughput.
// - FSM IDLE->RESP on accept.
//   - RESP->IDLE on resp_ack_i with no new accept.
//   - RESP->RESP on resp_ack_i with a new accept.
// - Commands; every command produces exactly one response:
//   - CLR=0: cnt=0, valid=0, best_*=0. Response 0.
//   - ACC1=1: evaluate src0. cnt+=1. Response best_idx after update.
//   - ACC2=2: evaluate src0 then src1. cnt+=2. Response best_idx after update.
//   - RD_IDX=3: response best_idx, or 32'hFFFF_FFFF if valid=0.
//   - RD_VAL=4: response best_val, sign-extended if SIGNED else zero-extended.
//   - RD_CNT=5: response {flags, cnt}. Bit31 = ~valid. Bit30 = ovf (only with ARGEXT_OVF_EN).
//   - 6 and 7: treated as RD_IDX.
// - Compare: "better" means strictly greater (max) or strictly less (min).
//   - Ties keep the earlier index; within a pair, src0 wins ties.
//   - The first element after CLR or reset is always taken (valid 0->1), whatever its value.
// - Index: best_idx = cnt (src0) or cnt+1 (src1). cnt wraps mod 2^IDX_W unless ARGEXT_OVF_EN.
//   - Responses are zero-extended to 32 bits.
// - Reset mid-response drops the pending response; no replay.
// CONFIGURATION
// - `ARGEXT_OVF_EN defined:
//   - Sticky ovf flag, set when cnt would pass 2^IDX_W-1.
//   - While ovf=1, ACC1/ACC2 leave state unchanged and respond 32'hFFFF_FFFE.
//   - CLR clears ovf.
// - `ARGEXT_OVF_EN undefined: cnt wraps silently; bit30 of RD_CNT reads 0.
// STRUCTURE
// - Package coproc_argext_pkg:
//   - argext_cmd_t enum (CLR, ACC1, ACC2, RD_IDX, RD_VAL, RD_CNT).
//   - argext_state_t enum (IDLE, RESP).
//   - Constants EMPTY_IDX=32'hFFFF_FFFF, OVF_RESP=32'hFFFF_FFFE.
// - Sub-module coproc_argext_cmp:
//   - Combinational pair selector: (best, valid, src0, src1, n_elems) -> (take, sel1, new_val).
//   - Parametrised by DATA_W, SIGNED, FIND_MIN.
// TESTING
// - Reset, CLR, then ACC2 {3,9}, ACC2 {9,2} -> responses 1, 1. RD_VAL -> 9. RD_CNT -> 4.
// - SIGNED=1, DATA_W=8: after CLR, ACC1 -5, ACC1 -2 -> idx 0 then 1. RD_VAL -> 32'hFFFF_FFFE (-2).
// - FIND_MIN=1: ACC2 {7,7}, ACC1 {7} -> idx 0, 0. Tie rule holds.
// - CLR then RD_IDX -> 32'hFFFF_FFFF. RD_CNT -> 32'h8000_0000.
// - Hold resp_ack_i=0 for 5 cycles after an ACC2:
//   - req_ack_o stays 0 and resp_data_bo is stable.
//   - Ack in the same cycle as a new req -> back-to-back accept.
// - IDX_W=2, ACC2 x3:
//   - With ARGEXT_OVF_EN: third response 32'hFFFF_FFFE.
//   - Without it: cnt wraps to 2.

Source files
------------

// File: rtl/coproc_argext_pkg.sv
// Shared types and response codes for the arg-max/arg-min stream coprocessor.
package coproc_argext_pkg;

    typedef enum logic [2:0] {
        CLR    = 3'd0,
        ACC1   = 3'd1,
        ACC2   = 3'd2,
        RD_IDX = 3'd3,
        RD_VAL = 3'd4,
        RD_CNT = 3'd5
    } argext_cmd_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } argext_state_t;

    localparam logic [31:0] EMPTY_IDX = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_RESP  = 32'hFFFF_FFFE;

endpackage

// File: rtl/coproc_argext_cmp.sv
// Pair selector: folds up to two new elements into the running best, src0 first.
// Combinational; no backpressure.
module coproc_argext_cmp #(
    parameter int DATA_W   = 32,
    parameter int SIGNED   = 0,
    parameter int FIND_MIN = 0
) (
    input  logic [DATA_W-1:0] i_best,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_src0,
    input  logic [DATA_W-1:0] i_src1,
    input  logic [1:0]        i_n_elems,
    output logic              o_take,
    output logic              o_sel1,
    output logic [DATA_W-1:0] o_new_val
);

    // Strict compare, so an equal value never displaces the earlier index.
    function automatic logic better(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        logic gt;
        logic lt;
        if (SIGNED != 0) begin
            gt = $signed(a) > $signed(b);
            lt = $signed(a) < $signed(b);
        end else begin
            gt = a > b;
            lt = a < b;
        end
        return (FIND_MIN != 0) ? lt : gt;
    endfunction

    logic              w_take0;
    logic              w_take1;
    logic [DATA_W-1:0] w_mid;

    always_comb begin
        w_take0   = (i_n_elems != 2'd0) && (!i_valid || better(i_src0, i_best));
        w_mid     = w_take0 ? i_src0 : i_best;
        w_take1   = (i_n_elems == 2'd2) && better(i_src1, w_mid);
        o_take    = w_take0 | w_take1;
        o_sel1    = w_take1;
        o_new_val = w_take1 ? i_src1 : w_mid;
    end

endmodule

// File: rtl/coproc_argext_stream.sv
// Running arg-max/arg-min coprocessor on a one-request/one-response port; ARGEXT_OVF_EN adds sticky index overflow.
// Latency: response valid the cycle after accept, held until resp_ack_i.
// Backpressure: a new request is accepted only when idle or when the pending response is acked that cycle.
module coproc_argext_stream
    import coproc_argext_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int IDX_W    = 16,
    parameter int SIGNED   = 0,
    parameter int FIND_MIN = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    output logic              req_ack_o,
    input  logic [2:0]        req_cmd_bi,
    input  logic [DATA_W-1:0] req_src0_bi,
    input  logic [DATA_W-1:0] req_src1_bi,
    output logic              resp_req_o,
    output logic [31:0]       resp_data_bo,
    input  logic              resp_ack_i
);

    argext_state_t     r_state;
    argext_state_t     w_state_nxt;
    logic [IDX_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_best_idx;
    logic [DATA_W-1:0] r_best_val;
    logic              r_valid;
    logic [31:0]       r_resp_data;

    logic              w_ovf;
    logic [1:0]        w_n_elems;
    logic [IDX_W-1:0]  w_cnt_nxt;
    logic              w_take;
    logic              w_sel1;
    logic [DATA_W-1:0] w_new_val;
    logic [IDX_W-1:0]  w_new_idx;
    logic [IDX_W-1:0]  w_idx_after;
    logic [31:0]       w_val_word;
    logic [31:0]       w_resp_nxt;
    logic              w_is_clr;

    assign req_ack_o = req_i & ((r_state == IDLE) | resp_ack_i);
    assign w_is_clr  = (req_cmd_bi == CLR);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        resp_req_o  = (r_state == RESP);
        case (r_state)
            IDLE: if (req_ack_o) w_state_nxt = RESP;
            RESP: if (resp_ack_i && !req_ack_o) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Overflowed accumulators are frozen by feeding zero elements to the selector.
    always_comb begin
        w_n_elems = 2'd0;
        if (!w_ovf) begin
            if (req_cmd_bi == ACC1) begin
                w_n_elems = 2'd1;
            end else if (req_cmd_bi == ACC2) begin
                w_n_elems = 2'd2;
            end
        end
    end

`ifdef ARGEXT_OVF_EN
    logic r_ovf;
    logic w_wrap;

    assign {w_wrap, w_cnt_nxt} = {1'b0, r_cnt} + (IDX_W + 1)'(w_n_elems);
    assign w_ovf = r_ovf;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_ovf <= 1'b0;
        end else if (req_ack_o) begin
            if (w_is_clr) begin
                r_ovf <= 1'b0;
            end else if (w_wrap) begin
                r_ovf <= 1'b1;
            end
        end
    end
`else
    assign w_cnt_nxt = r_cnt + IDX_W'(w_n_elems);
    assign w_ovf     = 1'b0;
`endif

    coproc_argext_cmp #(
        .DATA_W   (DATA_W),
        .SIGNED   (SIGNED),
        .FIND_MIN (FIND_MIN)
    ) u_cmp (
        .i_best    (r_best_val),
        .i_valid   (r_valid),
        .i_src0    (req_src0_bi),
        .i_src1    (req_src1_bi),
        .i_n_elems (w_n_elems),
        .o_take    (w_take),
        .o_sel1    (w_sel1),
        .o_new_val (w_new_val)
    );

    assign w_new_idx   = w_sel1 ? (r_cnt + IDX_W'(1)) : r_cnt;
    assign w_idx_after = w_take ? w_new_idx : r_best_idx;
    assign w_val_word  = (SIGNED != 0) ? 32'($signed(r_best_val)) : 32'(r_best_val);

    always_comb begin
        w_resp_nxt = r_valid ? 32'(r_best_idx) : EMPTY_IDX;
        case (req_cmd_bi)
            CLR:        w_resp_nxt = 32'd0;
            ACC1, ACC2: w_resp_nxt = w_ovf ? OVF_RESP : 32'(w_idx_after);
            RD_VAL:     w_resp_nxt = w_val_word;
            RD_CNT:     w_resp_nxt = {~r_valid, w_ovf, 30'(r_cnt)};
            default:    w_resp_nxt = r_valid ? 32'(r_best_idx) : EMPTY_IDX;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt       <= '0;
            r_best_idx  <= '0;
            r_best_val  <= '0;
            r_valid     <= 1'b0;
            r_resp_data <= 32'd0;
        end else if (req_ack_o) begin
            r_resp_data <= w_resp_nxt;
            if (w_is_clr) begin
                r_cnt      <= '0;
                r_best_idx <= '0;
                r_best_val <= '0;
                r_valid    <= 1'b0;
            end else if (w_n_elems != 2'd0) begin
                r_cnt <= w_cnt_nxt;
                if (w_take) begin
                    r_best_val <= w_new_val;
                    r_best_idx <= w_new_idx;
                    r_valid    <= 1'b1;
                end
            end
        end
    end

    assign resp_data_bo = r_resp_data;

endmodule

// File: tb/tb_coproc_argext_stream.sv
// Bench: four differently parametrised instances checked against a value-level model of the running arg-extreme.
module tb_coproc_argext_stream;
    import coproc_argext_pkg::*;

    localparam int N = 4;
`ifdef ARGEXT_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req       [N];
    logic        req_ack   [N];
    logic [2:0]  cmd       [N];
    logic [31:0] src0      [N];
    logic [31:0] src1      [N];
    logic        resp_req  [N];
    logic [31:0] resp_data [N];
    logic        resp_ack  [N];

    int checks   = 0;
    int failures = 0;

    longint      m_best  [N];
    int unsigned m_idx   [N];
    int unsigned m_cnt   [N];
    bit          m_valid [N];
    bit          m_ovf   [N];
    logic [31:0] exp_q   [N][$];

    always #5 clk = ~clk;

    // inst0: default max; inst1: 8-bit signed max; inst2: min; inst3: 2-bit index
    coproc_argext_stream u_dut0 (
        .clk_i(clk), .rst_i(rst), .req_i(req[0]), .req_ack_o(req_ack[0]), .req_cmd_bi(cmd[0]),
        .req_src0_bi(src0[0]), .req_src1_bi(src1[0]), .resp_req_o(resp_req[0]),
        .resp_data_bo(resp_data[0]), .resp_ack_i(resp_ack[0]));
    coproc_argext_stream #(.DATA_W(8), .SIGNED(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req[1]), .req_ack_o(req_ack[1]), .req_cmd_bi(cmd[1]),
        .req_src0_bi(src0[1][7:0]), .req_src1_bi(src1[1][7:0]), .resp_req_o(resp_req[1]),
        .resp_data_bo(resp_data[1]), .resp_ack_i(resp_ack[1]));
    coproc_argext_stream #(.FIND_MIN(1)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .req_i(req[2]), .req_ack_o(req_ack[2]), .req_cmd_bi(cmd[2]),
        .req_src0_bi(src0[2]), .req_src1_bi(src1[2]), .resp_req_o(resp_req[2]),
        .resp_data_bo(resp_data[2]), .resp_ack_i(resp_ack[2]));
    coproc_argext_stream #(.IDX_W(2)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .req_i(req[3]), .req_ack_o(req_ack[3]), .req_cmd_bi(cmd[3]),
        .req_src0_bi(src0[3]), .req_src1_bi(src1[3]), .resp_req_o(resp_req[3]),
        .resp_data_bo(resp_data[3]), .resp_ack_i(resp_ack[3]));

    function automatic int p_dw(int k);  return (k == 1) ? 8 : 32; endfunction
    function automatic bit p_sg(int k);  return (k == 1);          endfunction
    function automatic bit p_mn(int k);  return (k == 2);          endfunction
    function automatic int p_iw(int k);  return (k == 3) ? 2 : 16; endfunction

    // Element as a plain integer under the instance's width and signedness.
    function automatic longint elem_value(int k, logic [31:0] x);
        longint v;
        int dw;
        dw = p_dw(k);
        v  = longint'(x) & ((64'sd1 <<< dw) - 64'sd1);
        if (p_sg(k) && v[dw-1]) v = v - (64'sd1 <<< dw);
        return v;
    endfunction

    function automatic void model_clear(int k);
        m_best[k]  = 0;
        m_idx[k]   = 0;
        m_cnt[k]   = 0;
        m_valid[k] = 1'b0;
        m_ovf[k]   = 1'b0;
    endfunction

    function automatic logic [31:0] model(int k, logic [2:0] c, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        longint      v;
        longint      lim;
        bit          better;
        lim = 64'sd1 <<< p_iw(k);
        case (c)
            3'd0: begin
                model_clear(k);
                r = 32'd0;
            end
            3'd1, 3'd2: begin
                if (OVF_EN && m_ovf[k]) begin
                    r = 32'hFFFF_FFFE;
                end else begin
                    for (int i = 0; i < int'(c); i++) begin
                        v      = elem_value(k, (i == 0) ? a : b);
                        better = p_mn(k) ? (v < m_best[k]) : (v > m_best[k]);
                        if (!m_valid[k] || better) begin
                            m_best[k]  = v;
                            m_idx[k]   = int'((longint'(m_cnt[k]) + i) % lim);
                            m_valid[k] = 1'b1;
                        end
                    end
                    m_cnt[k] = m_cnt[k] + int'(c);
                    if (longint'(m_cnt[k]) >= lim) begin
                        if (OVF_EN) m_ovf[k] = 1'b1;
                        m_cnt[k] = m_cnt[k] - int'(lim);
                    end
                    r = m_idx[k];
                end
            end
            3'd4:    r = m_best[k][31:0];
            3'd5:    r = {~m_valid[k], m_ovf[k], 30'(m_cnt[k])};
            default: r = m_valid[k] ? m_idx[k] : 32'hFFFF_FFFF;
        endcase
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, req_v);
        end
    endtask

    // Any valid response must equal the oldest outstanding expectation, every cycle until acked.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                if (resp_req[k]) begin
                    checks++;
                    if (exp_q[k].size() == 0) begin
                        failures++;
                        $display("FAIL resp_unexpected inst=%0d actual=%h required=none", k, resp_data[k]);
                    end else begin
                        if (resp_data[k] !== exp_q[k][0]) begin
                            failures++;
                            $display("FAIL resp_data inst=%0d actual=%h required=%h", k, resp_data[k], exp_q[k][0]);
                        end
                        if (resp_ack[k]) void'(exp_q[k].pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input int k, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] e);
        int t;
        e = model(k, c, a, b);
        exp_q[k].push_back(e);
        req[k]  = 1'b1;
        cmd[k]  = c;
        src0[k] = a;
        src1[k] = b;
        t = 0;
        @(negedge clk);
        while (!req_ack[k] && t < 40) begin
            t++;
            @(negedge clk);
        end
        if (!req_ack[k]) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout inst=%0d actual=no_ack required=ack", k);
        end
        @(posedge clk);
        #1;
        req[k] = 1'b0;
    endtask

    task automatic drain(input int k);
        int t;
        t = 0;
        while (exp_q[k].size() != 0 && t < 50) begin
            t++;
            @(posedge clk);
        end
        #1;
        if (exp_q[k].size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout inst=%0d actual=%0d required=0", k, exp_q[k].size());
            exp_q[k].delete();
        end
    endtask

    initial begin
        logic [31:0] e;
        logic [31:0] held;

        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            req[k] = 1'b0; cmd[k] = 3'd0; src0[k] = '0; src1[k] = '0; resp_ack[k] = 1'b1;
            model_clear(k);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            chk($sformatf("reset_resp_req%0d", k), 32'(resp_req[k]), 32'd0);
            chk($sformatf("reset_resp_data%0d", k), resp_data[k], 32'd0);
            chk($sformatf("reset_req_ack%0d", k), 32'(req_ack[k]), 32'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Basic arg-max with a tie in the second pair
        send(0, 3'd0, 0, 0, e);
        send(0, 3'd2, 3, 9, e);  chk("max_acc2_a", e, 32'd1);
        send(0, 3'd2, 9, 2, e);  chk("max_acc2_b", e, 32'd1);
        send(0, 3'd4, 0, 0, e);  chk("max_rd_val", e, 32'd9);
        send(0, 3'd5, 0, 0, e);  chk("max_rd_cnt", e, 32'd4);
        send(0, 3'd7, 0, 0, e);  chk("max_cmd7", e, 32'd1);
        drain(0);

        // 8-bit signed compare with sign-extended readback
        send(1, 3'd0, 0, 0, e);
        send(1, 3'd1, 32'hFB, 0, e); chk("sgn_first", e, 32'd0);
        send(1, 3'd1, 32'hFE, 0, e); chk("sgn_second", e, 32'd1);
        send(1, 3'd4, 0, 0, e);      chk("sgn_rd_val", e, 32'hFFFF_FFFE);
        send(1, 3'd1, 32'h7F, 0, e); chk("sgn_pos", e, 32'd2);
        send(1, 3'd1, 32'h80, 0, e); chk("sgn_most_neg", e, 32'd2);
        send(1, 3'd4, 0, 0, e);      chk("sgn_rd_val2", e, 32'h7F);
        drain(1);

        // Arg-min tie rule
        send(2, 3'd0, 0, 0, e);
        send(2, 3'd2, 7, 7, e);  chk("min_pair_tie", e, 32'd0);
        send(2, 3'd1, 7, 0, e);  chk("min_tie", e, 32'd0);
        send(2, 3'd2, 5, 3, e);  chk("min_pair_src1", e, 32'd4);
        send(2, 3'd4, 0, 0, e);  chk("min_rd_val", e, 32'd3);
        drain(2);

        // Empty accumulator reads
        send(0, 3'd0, 0, 0, e);
        send(0, 3'd3, 0, 0, e);  chk("empty_rd_idx", e, 32'hFFFF_FFFF);
        send(0, 3'd5, 0, 0, e);  chk("empty_rd_cnt", e, 32'h8000_0000);
        send(0, 3'd4, 0, 0, e);  chk("empty_rd_val", e, 32'd0);
        drain(0);

        // 2-bit index: overflow protection or silent wrap depending on build
        send(3, 3'd0, 0, 0, e);
        send(3, 3'd2, 1, 2, e);  chk("idx2_acc_a", e, 32'd1);
        send(3, 3'd2, 3, 4, e);  chk("idx2_acc_b", e, 32'd3);
        send(3, 3'd2, 5, 6, e);  chk("idx2_acc_c", e, OVF_EN ? 32'hFFFF_FFFE : 32'd1);
        send(3, 3'd5, 0, 0, e);  chk("idx2_rd_cnt", e, OVF_EN ? 32'h4000_0000 : 32'd2);
        send(3, 3'd0, 0, 0, e);
        send(3, 3'd5, 0, 0, e);  chk("idx2_clr_cnt", e, 32'h8000_0000);
        drain(3);

        // Response backpressure, then accept-while-ack
        send(0, 3'd0, 0, 0, e);
        drain(0);
        resp_ack[0] = 1'b0;
        send(0, 3'd2, 10, 20, e); chk("bp_acc2", e, 32'd1);
        held = resp_data[0];
        chk("bp_held_value", held, 32'd1);
        req[0] = 1'b1; cmd[0] = 3'd4; src0[0] = '0; src1[0] = '0;
        exp_q[0].push_back(model(0, 3'd4, 0, 0));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_req_ack_low", 32'(req_ack[0]), 32'd0);
            chk("bp_data_stable", resp_data[0], held);
            chk("bp_resp_req", 32'(resp_req[0]), 32'd1);
        end
        @(posedge clk);
        #1;
        resp_ack[0] = 1'b1;
        #1;
        chk("b2b_accept", 32'(req_ack[0]), 32'd1);
        @(posedge clk);
        #1;
        req[0] = 1'b0;
        chk("b2b_resp_req", 32'(resp_req[0]), 32'd1);
        chk("b2b_resp_data", resp_data[0], 32'd20);
        drain(0);

        // Reset with a response pending drops it
        resp_ack[0] = 1'b0;
        send(0, 3'd5, 0, 0, e);
        rst = 1'b1;
        #2;
        chk("rst_mid_resp_req", 32'(resp_req[0]), 32'd0);
        chk("rst_mid_resp_data", resp_data[0], 32'd0);
        for (int k = 0; k < N; k++) begin
            exp_q[k].delete();
            model_clear(k);
        end
        resp_ack[0] = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        send(0, 3'd3, 0, 0, e);  chk("post_rst_rd_idx", e, 32'hFFFF_FFFF);
        send(0, 3'd1, 5, 0, e);  chk("post_rst_acc1", e, 32'd0);

        for (int k = 0; k < N; k++) drain(k);
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

endmodule
